// File: rtl/cache_read_mux_pkg.sv
// rtl/cache_read_mux_pkg.sv - shared constants, load encodings and decode helper
package cache_pkg;

  localparam int WORD_W    = 32;
  localparam int DEF_WAYS  = 2;
  localparam int DEF_WORDS = 4;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b100,
    LT_LHU = 3'b101
  } load_e;

  // Reserved funct3 codes fall back to a full-word load.
  function automatic load_e decode_load(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return LT_LB;
      3'b001:  return LT_LH;
      3'b100:  return LT_LBU;
      3'b101:  return LT_LHU;
      default: return LT_LW;
    endcase
  endfunction

endpackage

// File: rtl/cache_read_mux_if.sv
// rtl/cache_read_mux_if.sv - request/response bundle between cache arrays and load path
interface cache_read_mux_if
  import cache_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int WORDS = DEF_WORDS
) ();

  localparam int OFF_W = $clog2(WORDS) + 2;

  logic                        req_valid;
  logic                        stall;
  logic [WAYS-1:0]             hit;
  logic [WAYS*WORDS*WORD_W-1:0] line_data;
  logic [OFF_W-1:0]            addr_off;
  logic [2:0]                  load_type;

  logic [WORD_W-1:0]           rdata;
  logic                        rdata_valid;
  logic                        miss;
  logic                        multi_hit;
  logic                        misalign;
  logic [31:0]                 hit_cnt;
  logic [31:0]                 miss_cnt;

  modport master (
    output req_valid, stall, hit, line_data, addr_off, load_type,
    input  rdata, rdata_valid, miss, multi_hit, misalign, hit_cnt, miss_cnt
  );

  modport slave (
    input  req_valid, stall, hit, line_data, addr_off, load_type,
    output rdata, rdata_valid, miss, multi_hit, misalign, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/cache_read_mux_way_encoder.sv
// rtl/cache_read_mux_way_encoder.sv - hit vector to lowest-set way index plus zero/one/many flags
module way_encoder #(
  parameter int WAYS = 2
) (
  input  logic [WAYS-1:0]         i_hit,
  output logic [$clog2(WAYS)-1:0] o_idx,
  output logic                    o_zero,
  output logic                    o_one,
  output logic                    o_many
);

  localparam int IDX_W = $clog2(WAYS);

  logic w_many;

  // Descending scan so the lowest set bit wins.
  always_comb begin
    o_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_hit[w]) o_idx = IDX_W'(w);
    end
  end

  assign w_many = |(i_hit & (i_hit - WAYS'(1)));
  assign o_zero = ~|i_hit;
  assign o_many = w_many;
  assign o_one  = ~o_zero & ~w_many;

endmodule

// File: rtl/cache_read_mux.sv
// rtl/cache_read_mux.sv - way/word select, load extraction and extension, registered flags and counters
module cache_read_mux
  import cache_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int WORDS = DEF_WORDS
) (
  input  logic clk,
  input  logic rst,
  cache_read_mux_if.slave bus
);

  localparam int IDX_W = $clog2(WAYS);

  logic [IDX_W-1:0]  w_idx;
  logic              w_zero;
  logic              w_one;
  logic              w_many;
  logic [31:0]       w_widx;
  logic [WORD_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  load_e             w_lt;
  logic [WORD_W-1:0] w_ext;
  logic              w_misalign;
  logic              w_accept;

  logic [WORD_W-1:0] r_rdata;
  logic              r_rdata_valid;
  logic              r_miss;
  logic              r_multi_hit;
  logic              r_misalign;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  way_encoder #(.WAYS(WAYS)) u_way_encoder (
    .i_hit  (bus.hit),
    .o_idx  (w_idx),
    .o_zero (w_zero),
    .o_one  (w_one),
    .o_many (w_many)
  );

  assign w_widx = 32'(bus.addr_off) >> 2;

  always_comb begin
    w_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int k = 0; k < WORDS; k++) begin
        if (w_idx == IDX_W'(w) && w_widx == 32'(k))
          w_word = bus.line_data[(w*WORDS+k)*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    w_byte = w_word[7:0];
    case (bus.addr_off[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  assign w_half = bus.addr_off[1] ? w_word[31:16] : w_word[15:0];
  assign w_lt   = decode_load(bus.load_type);

  always_comb begin
    w_ext      = w_word;
    w_misalign = 1'b0;
    case (w_lt)
      LT_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
      LT_LBU: w_ext = {24'd0, w_byte};
      LT_LH: begin
        w_ext      = {{16{w_half[15]}}, w_half};
        w_misalign = bus.addr_off[0];
      end
      LT_LHU: begin
        w_ext      = {16'd0, w_half};
        w_misalign = bus.addr_off[0];
      end
      default: begin
        w_ext      = w_word;
        w_misalign = |bus.addr_off[1:0];
      end
    endcase
  end

  assign w_accept = bus.req_valid & ~bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_miss        <= 1'b0;
      r_multi_hit   <= 1'b0;
      r_misalign    <= 1'b0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else if (!bus.stall) begin
      if (w_accept) begin
        r_rdata       <= w_ext;
        r_rdata_valid <= w_one & ~w_misalign;
        r_miss        <= w_zero;
        r_multi_hit   <= w_many;
        r_misalign    <= w_misalign;
        if (w_one && r_hit_cnt != '1)
          r_hit_cnt <= r_hit_cnt + 32'd1;
        if (w_zero && r_miss_cnt != '1)
          r_miss_cnt <= r_miss_cnt + 32'd1;
      end else begin
        // Idle cycle clears flags but keeps the last data visible.
        r_rdata_valid <= 1'b0;
        r_miss        <= 1'b0;
        r_multi_hit   <= 1'b0;
        r_misalign    <= 1'b0;
      end
    end
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.miss        = r_miss;
  assign bus.multi_hit   = r_multi_hit;
  assign bus.misalign    = r_misalign;
  assign bus.hit_cnt     = r_hit_cnt;
  assign bus.miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_cache_read_mux.sv
// tb/tb_cache_read_mux.sv - directed self-checking bench for cache_read_mux
module tb_cache_read_mux;

  localparam int WAYS  = 4;
  localparam int WORDS = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  cache_read_mux_if #(.WAYS(WAYS), .WORDS(WORDS)) bus ();

  cache_read_mux #(.WAYS(WAYS), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic s, input logic [3:0] h,
                         input logic [3:0] off, input logic [2:0] lt);
    bus.req_valid = v;
    bus.stall     = s;
    bus.hit       = h;
    bus.addr_off  = off;
    bus.load_type = lt;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] rd, input logic v,
                         input logic m, input logic mh, input logic ma,
                         input logic [31:0] hc, input logic [31:0] mc);
    chk_eq({tag, ".rdata"},     bus.rdata, rd);
    chk_eq({tag, ".valid"},     32'(bus.rdata_valid), 32'(v));
    chk_eq({tag, ".miss"},      32'(bus.miss), 32'(m));
    chk_eq({tag, ".multi"},     32'(bus.multi_hit), 32'(mh));
    chk_eq({tag, ".misalign"},  32'(bus.misalign), 32'(ma));
    chk_eq({tag, ".hit_cnt"},   bus.hit_cnt, hc);
    chk_eq({tag, ".miss_cnt"},  bus.miss_cnt, mc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_req(1'b0, 1'b0, 4'b0000, 4'h0, 3'b010);
    for (int w = 0; w < WAYS; w++)
      for (int k = 0; k < WORDS; k++)
        bus.line_data[(w*WORDS+k)*32 +: 32] = 32'hA000_0000 | 32'(w << 4) | 32'(k);
    bus.line_data[(0*WORDS+0)*32 +: 32] = 32'h2222_2222;
    bus.line_data[(1*WORDS+0)*32 +: 32] = 32'h1234_5678;
    bus.line_data[(2*WORDS+3)*32 +: 32] = 32'h8081_F0FF;

    #2;
    chk_out("reset", 32'h0, 0, 0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    set_req(1, 0, 4'b0001, 4'h0, 3'b010); step();
    chk_out("lw_way0", 32'h2222_2222, 1, 0, 0, 0, 32'd1, 32'd0);
    set_req(1, 0, 4'b0010, 4'h0, 3'b010); step();
    chk_out("lw_way1", 32'h1234_5678, 1, 0, 0, 0, 32'd2, 32'd0);
    set_req(1, 0, 4'b0100, 4'hD, 3'b000); step();
    chk_out("lb", 32'hFFFF_FFF0, 1, 0, 0, 0, 32'd3, 32'd0);
    set_req(1, 0, 4'b0100, 4'hD, 3'b100); step();
    chk_out("lbu", 32'h0000_00F0, 1, 0, 0, 0, 32'd4, 32'd0);
    set_req(1, 0, 4'b0100, 4'hE, 3'b001); step();
    chk_out("lh", 32'hFFFF_8081, 1, 0, 0, 0, 32'd5, 32'd0);
    set_req(1, 0, 4'b0100, 4'hE, 3'b101); step();
    chk_out("lhu", 32'h0000_8081, 1, 0, 0, 0, 32'd6, 32'd0);
    set_req(1, 0, 4'b0100, 4'hC, 3'b011); step();
    chk_out("lt011_as_lw", 32'h8081_F0FF, 1, 0, 0, 0, 32'd7, 32'd0);
    set_req(1, 0, 4'b0100, 4'h2, 3'b010); step();
    chk_out("lw_misalign", 32'hA000_0020, 0, 0, 0, 1, 32'd8, 32'd0);
    set_req(1, 0, 4'b0100, 4'h1, 3'b001); step();
    chk_out("lh_misalign", 32'h0000_0020, 0, 0, 0, 1, 32'd9, 32'd0);
    set_req(1, 0, 4'b0000, 4'h0, 3'b010); step();
    chk_eq("miss.valid", 32'(bus.rdata_valid), 32'd0);
    chk_eq("miss.flag", 32'(bus.miss), 32'd1);
    chk_eq("miss.hit_cnt", bus.hit_cnt, 32'd9);
    chk_eq("miss.miss_cnt", bus.miss_cnt, 32'd1);
    set_req(1, 0, 4'b0110, 4'h4, 3'b010); step();
    chk_out("multi", 32'hA000_0011, 0, 0, 1, 0, 32'd9, 32'd1);
    set_req(0, 0, 4'b0001, 4'h0, 3'b010); step();
    chk_out("idle", 32'hA000_0011, 0, 0, 0, 0, 32'd9, 32'd1);

    set_req(1, 0, 4'b0001, 4'h0, 3'b010); step();
    chk_out("pre_stall", 32'h2222_2222, 1, 0, 0, 0, 32'd10, 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1, (i == 0) ? 4'b0000 : 4'b0110, 4'(i + 5), 3'b000);
      step();
      chk_out($sformatf("stall%0d", i), 32'h2222_2222, 1, 0, 0, 0, 32'd10, 32'd1);
    end
    set_req(1, 0, 4'b0000, 4'h0, 3'b010); step();
    chk_eq("resume.miss", 32'(bus.miss), 32'd1);
    chk_eq("resume.miss_cnt", bus.miss_cnt, 32'd2);
    chk_eq("resume.hit_cnt", bus.hit_cnt, 32'd10);

    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_cnt;
    for (int i = 0; i < 2; i++) begin
      set_req(1, 0, 4'b0010, 4'h0, 3'b010); step();
      chk_eq($sformatf("sat%0d.hit_cnt", i), bus.hit_cnt, 32'hFFFF_FFFF);
      chk_eq($sformatf("sat%0d.rdata", i), bus.rdata, 32'h1234_5678);
    end

    set_req(1, 0, 4'b1000, 4'h8, 3'b010);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 32'h0, 0, 0, 0, 0, 32'd0, 32'd0);
    @(negedge clk);
    chk_out("rst_held", 32'h0, 0, 0, 0, 0, 32'd0, 32'd0);
    rst = 1'b0;
    step();
    chk_out("post_rst", 32'hA000_0032, 1, 0, 0, 0, 32'd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
